id_bypass_scoreboard: RTL

Parametrised operand-resolution unit for the decode stage. It selects the newest value for each source register from a configurable number of in-flight pipeline stages, and generates the read-after-write stall. It also adds a register scoreboard for long-latency operations (divider, multi-cycle multiplier) that stay in flight past the normal EX/MEM/WB forwarding window. It sits between the regfile read ports and the decode-to-execute handshake, and replaces the fixed three-source, three-stage compare/forward logic of the current decode stage.

---
 rtl/id_bypass_scoreboard_if.sv | 45 ++++
 rtl/id_bypass_scoreboard.sv | 113 +++++++++++
 2 files changed

// File: rtl/id_bypass_scoreboard_if.sv
// Decode-stage operand resolution bus: source reads, forwarding stages,
// long-latency issue/writeback and the resolved results.
interface id_bypass_scoreboard_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AW      = 5
);
  localparam int unsigned NREG = 1 << AW;

  logic [NUM_SRC*AW-1:0]     src_addr;
  logic [NUM_SRC-1:0]        src_used;
  logic [NUM_SRC*DATA_W-1:0] rf_rdata;
  logic [NUM_SRC*DATA_W-1:0] src_value;
  logic [NUM_FWD*AW-1:0]     fwd_dest;
  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      issue_fire;
  logic                      issue_long;
  logic [AW-1:0]             issue_dest;
  logic                      lwb_valid;
  logic [AW-1:0]             lwb_dest;
  logic [DATA_W-1:0]         lwb_data;
  logic                      sb_flush;
  logic                      stall;
  logic [NREG-1:0]           busy_vec;
  logic [31:0]               stall_cnt;

  // Decode side: drives operands and pipeline state, consumes results.
  modport master (
    output src_addr, src_used, rf_rdata, fwd_dest, fwd_we, fwd_ready, fwd_data,
           issue_fire, issue_long, issue_dest, lwb_valid, lwb_dest, lwb_data,
           sb_flush,
    input  src_value, stall, busy_vec, stall_cnt
  );

  // Resolution unit side.
  modport slave (
    input  src_addr, src_used, rf_rdata, fwd_dest, fwd_we, fwd_ready, fwd_data,
           issue_fire, issue_long, issue_dest, lwb_valid, lwb_dest, lwb_data,
           sb_flush,
    output src_value, stall, busy_vec, stall_cnt
  );
endinterface

// File: rtl/id_bypass_scoreboard.sv
// Operand resolution for decode: picks the newest value of each source
// register from the forwarding stages, long-latency writeback or regfile,
// raises RAW/WAW stall, and tracks outstanding long-latency destinations.
module id_bypass_scoreboard #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned AW      = 5
) (
  input logic                    clk,
  input logic                    reset,
  id_bypass_scoreboard_if.slave  bus
);
  localparam int unsigned NREG = 1 << AW;

  logic [NREG-1:0]           busy_q;
  logic [NREG-1:0]           busy_d;
  logic [NREG-1:0]           busy_eff;
  logic [NUM_SRC-1:0]        slot_stall;
  logic [NUM_SRC*DATA_W-1:0] src_value_c;
  logic                      waw_stall;
  logic                      stall_c;
  logic                      set_en;
  logic [31:0]               stall_cnt_q;

  logic [AW-1:0]             addr_t;
  logic [DATA_W-1:0]         val_t;
  logic                      hit_t;
  logic                      stl_t;

  // Scoreboard seen by the combinational path; reads as empty during reset.
  assign busy_eff = reset ? '0 : busy_q;

  // Per-slot resolution: r0, long writeback bypass, youngest stage, scoreboard, regfile.
  always_comb begin
    src_value_c = '0;
    slot_stall  = '0;
    addr_t      = '0;
    val_t       = '0;
    hit_t       = 1'b0;
    stl_t       = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      addr_t = bus.src_addr[i*AW +: AW];
      val_t  = bus.rf_rdata[i*DATA_W +: DATA_W];
      hit_t  = 1'b0;
      stl_t  = 1'b0;
      if (addr_t == '0) begin
        val_t = '0;
      end else if (bus.lwb_valid && (bus.lwb_dest == addr_t)) begin
        val_t = bus.lwb_data;
      end else begin
        for (int unsigned k = 0; k < NUM_FWD; k++) begin
          if (!hit_t && bus.fwd_we[k] && (bus.fwd_dest[k*AW +: AW] == addr_t)) begin
            hit_t = 1'b1;
            if (bus.fwd_ready[k]) begin
              val_t = bus.fwd_data[k*DATA_W +: DATA_W];
            end else begin
              stl_t = 1'b1;
            end
          end
        end
        if (!hit_t && busy_eff[addr_t]) begin
          stl_t = 1'b1;
        end
      end
      src_value_c[i*DATA_W +: DATA_W] = val_t;
      slot_stall[i] = stl_t & bus.src_used[i];
    end
  end

  // A second long op to a still-busy register waits unless it retires this cycle.
  assign waw_stall = bus.issue_long && busy_eff[bus.issue_dest] &&
                     !(bus.lwb_valid && (bus.lwb_dest == bus.issue_dest));
  assign stall_c   = (|slot_stall) | waw_stall;
  assign set_en    = bus.issue_fire & bus.issue_long & (bus.issue_dest != '0) & ~stall_c;

  // Next scoreboard: clear on writeback, set on issue (set wins), flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (bus.lwb_valid) begin
      busy_d[bus.lwb_dest] = 1'b0;
    end
    if (set_en) begin
      busy_d[bus.issue_dest] = 1'b1;
    end
    if (bus.sb_flush) begin
      busy_d = '0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Saturating stall-cycle counter; survives flushes.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.src_value = src_value_c;
  assign bus.stall     = stall_c;
  assign bus.busy_vec  = busy_q;
  assign bus.stall_cnt = stall_cnt_q;
endmodule
